// File: rtl/block_data_memory.sv
`default_nettype none
// ============================================================================
//  Module      : block_data_memory
//  Description : Block-organised data memory moving one cache line per request
//                as a sequence of multi-byte beats under a BUSYWAIT handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module block_data_memory #(
   parameter int  ADDR_WIDTH       = 6,
   parameter int  BLOCK_BYTES_LOG2 = 4,
   parameter int  BEAT_BYTES_LOG2  = 0,
   localparam int BLOCK_BITS       = 8 << BLOCK_BYTES_LOG2
) (
   input  logic                  CLOCK,
   input  logic                  RESET,
   input  logic                  READ_EN,
   input  logic                  WRITE_EN,
   input  logic [ADDR_WIDTH-1:0] ADDRESS,
   input  logic [BLOCK_BITS-1:0] WRITE_DATA,
   output logic [BLOCK_BITS-1:0] READ_DATA,
   output logic                  BUSYWAIT,
   output logic                  PROTO_ERR
);

   localparam int c_BEAT_BYTES = 1 << BEAT_BYTES_LOG2;
   localparam int c_BEAT_BITS  = 8 * c_BEAT_BYTES;
   localparam int c_CNT_LOG2   = BLOCK_BYTES_LOG2 - BEAT_BYTES_LOG2;
   localparam int c_NBEATS     = 1 << c_CNT_LOG2;
   localparam int c_BEAT_W     = (c_CNT_LOG2 > 0) ? c_CNT_LOG2 : 1;
   localparam int c_MEM_AW     = ADDR_WIDTH + BLOCK_BYTES_LOG2;
   localparam int c_DEPTH      = 1 << c_MEM_AW;
   localparam int c_BIT_W      = BLOCK_BYTES_LOG2 + 3;
   localparam logic [c_BEAT_W-1:0] c_LAST_BEAT = c_BEAT_W'(c_NBEATS - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_XFER = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t                  r_state;
   state_t                  w_state_next;
   logic [c_BEAT_W-1:0]     r_beat;
   logic [ADDR_WIDTH-1:0]   r_addr;
   logic [BLOCK_BITS-1:0]   r_wdata;
   logic                    r_is_write;
   logic [BLOCK_BITS-1:0]   r_line;
   logic [BLOCK_BITS-1:0]   w_line_merged;
   logic [7:0]              r_mem [0:c_DEPTH-1];
   logic [c_MEM_AW-1:0]     w_beat_base;
   logic [c_BIT_W-1:0]      w_bit_off;
   logic [c_BEAT_BITS-1:0]  w_rd_beat;
   logic [c_BEAT_BITS-1:0]  w_wr_beat;
   logic                    w_valid;
   logic                    w_xfer;
   logic                    w_last_beat;

   assign w_valid     = READ_EN ^ WRITE_EN;
   assign w_xfer      = (r_state == ST_XFER);
   assign w_last_beat = (r_beat == c_LAST_BEAT);
   assign w_beat_base = (c_MEM_AW'(r_addr) << BLOCK_BYTES_LOG2)
                      | (c_MEM_AW'(r_beat) << BEAT_BYTES_LOG2);
   assign w_bit_off   = c_BIT_W'(r_beat) << (BEAT_BYTES_LOG2 + 3);
   assign w_wr_beat   = r_wdata[w_bit_off +: c_BEAT_BITS];

   always_comb begin
      w_rd_beat = '0;
      for (int j = 0; j < c_BEAT_BYTES; j++) begin
         w_rd_beat[8*j +: 8] = r_mem[w_beat_base + c_MEM_AW'(j)];
      end
   end

   // Line buffer with the current beat spliced in, so the final beat can be
   // published to READ_DATA on the same edge that fetches it.
   always_comb begin
      w_line_merged = r_line;
      w_line_merged[w_bit_off +: c_BEAT_BITS] = w_rd_beat;
   end

   always_comb begin
      w_state_next = r_state;
      BUSYWAIT     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_valid) begin
               w_state_next = ST_XFER;
               BUSYWAIT     = 1'b1;
            end
         end
         ST_XFER: begin
            BUSYWAIT = 1'b1;
            if (w_last_beat) begin
               w_state_next = ST_DONE;
            end
         end
         ST_DONE: w_state_next = ST_IDLE;
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         r_beat    <= '0;
         READ_DATA <= '0;
         PROTO_ERR <= 1'b0;
      end else begin
         PROTO_ERR <= (r_state == ST_IDLE) && READ_EN && WRITE_EN;
         if (r_state == ST_IDLE) begin
            r_beat <= '0;
         end else if (w_xfer) begin
            r_beat <= r_beat + c_BEAT_W'(1);
         end
         if (w_xfer && !r_is_write && w_last_beat) begin
            READ_DATA <= w_line_merged;
         end
      end
   end

   // Request capture and line buffer carry no reset; they are only consumed
   // while a transfer is in flight.
   always_ff @(posedge CLOCK) begin
      if (r_state == ST_IDLE && w_valid) begin
         r_addr     <= ADDRESS;
         r_wdata    <= WRITE_DATA;
         r_is_write <= WRITE_EN;
      end
      if (w_xfer && !r_is_write) begin
         r_line <= w_line_merged;
      end
   end

   always_ff @(posedge CLOCK) begin
      if (w_xfer && r_is_write) begin
         for (int j = 0; j < c_BEAT_BYTES; j++) begin
            r_mem[w_beat_base + c_MEM_AW'(j)] <= w_wr_beat[8*j +: 8];
         end
      end
   end

endmodule
`default_nettype wire

// File: doc/block_data_memory.md
Name: block_data_memory

Overview:
Parametrised, block-organised data memory that serves whole cache-line reads and writes for the data cache. Each request is transferred as a sequence of multi-byte beats, so access latency scales with block size and beat width. A BUSYWAIT handshake stalls the cache until the transfer completes. This block replaces the fixed 16-byte, byte-serial memory with a captured-request FSM, configurable geometry and protocol-error detection.

Parameters:
ADDR_WIDTH, 6, block address bits; depth = 2^ADDR_WIDTH blocks
BLOCK_BYTES_LOG2, 4, log2 of bytes per block; BLOCK_BITS = 8 << BLOCK_BYTES_LOG2
BEAT_BYTES_LOG2, 0, log2 of bytes moved per cycle; must be <= BLOCK_BYTES_LOG2; NBEATS = 2^(BLOCK_BYTES_LOG2 - BEAT_BYTES_LOG2)

Ports:
CLOCK  in  1  clock, rising edge
RESET  in  1  asynchronous, active-high reset
READ_EN  in  1  block read request
WRITE_EN  in  1  block write request
ADDRESS  in  ADDR_WIDTH  block address
WRITE_DATA  in  BLOCK_BITS  write block; byte k sits at bits [8k+7:8k]
READ_DATA  out  BLOCK_BITS  last completed read block, registered
BUSYWAIT  out  1  stall to the requester
PROTO_ERR  out  1  one-cycle registered pulse when both enables are high in IDLE

Behaviour:
- Storage: byte array of 2^(ADDR_WIDTH+BLOCK_BYTES_LOG2) entries, indexed {block address, byte offset}. Not cleared by RESET; undefined at power-up.
- Reset (async): state=IDLE, beat counter=0, READ_DATA=0, PROTO_ERR=0. BUSYWAIT therefore reads 0 unless a valid request is present in IDLE.
- Valid request: READ_EN xor WRITE_EN.
- BUSYWAIT (combinational) = (state==XFER) or (state==IDLE and valid request).
- IDLE:
  - On a rising edge with a valid request: capture ADDRESS, WRITE_DATA and op; clear the beat counter; go to XFER.
  - Both enables high: no capture; stay IDLE; PROTO_ERR=1 next cycle. BUSYWAIT stays 0.
- XFER, beat i:
  - Each rising edge moves bytes [i*BEAT_BYTES, (i+1)*BEAT_BYTES-1] of the captured block.
  - Write: the captured data is written into the array.
  - Read: array bytes are loaded into an internal line buffer.
  - The counter increments; after beat NBEATS-1 go to DONE.
- DONE:
  - For a read, READ_DATA is loaded from the line buffer on the edge entering DONE. It holds until the next read completes; writes never change it.
  - BUSYWAIT=0 for this one cycle. The next edge always returns to IDLE.
- Latency: BUSYWAIT is high for exactly NBEATS+1 cycles (1 IDLE + NBEATS XFER), then low for the DONE cycle. Default configuration: 17 high, 1 low.
- Captured request: changes to ADDRESS, WRITE_DATA or the enables during XFER are ignored. Dropping the enable mid-XFER does not abort the transfer.
- Back-to-back: if a valid request is present in the IDLE cycle after DONE, a new transaction starts. Minimum spacing between accesses is NBEATS+2 cycles.
- Reset mid-XFER: aborts immediately and returns to IDLE. Bytes already written stay written; unwritten bytes keep their old values. READ_DATA=0.
- Address wrap: none. The full address range maps 1:1 to the array.

Test Plan:
- Write 0x0F0E..0100 (byte k = k) to block 3, then read block 3 → BUSYWAIT high 17 cycles for each op; READ_DATA = 0x0F0E0D0C0B0A09080706050403020100 in the read DONE cycle.
- BEAT_BYTES_LOG2=2: write and read block 63 with 0xDEADBEEF_CAFEBABE_01234567_89ABCDEF → BUSYWAIT high 5 cycles; data matches.
- Write block 5 with all 0xAA, then write all 0x55 and assert RESET after the 6th XFER beat; read block 5 → bytes 0-5 = 0x55, bytes 6-15 = 0xAA; READ_DATA=0 right after reset.
- READ_EN=WRITE_EN=1 in IDLE → BUSYWAIT=0, PROTO_ERR pulses for 1 cycle, memory and READ_DATA unchanged.
- Read block 1, changing ADDRESS to 2 and dropping READ_EN at beat 4 → transfer completes with block 1 data; BUSYWAIT low one cycle, then IDLE.
- Back-to-back read blocks 1 then 2 with READ_EN held high → DONE pulse BUSYWAIT=0 once; second read completes 18 cycles after the first.
